// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch outcome predictor.
package bp_pkg;

  localparam int unsigned PC_W = 32;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [PC_W-1:0] PC_STEP = 32'd4;

  typedef enum logic {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } bp_state_e;

  // Word-aligned table index; caller truncates to its index width.
  function automatic logic [PC_W-1:0] pc_index(input logic [PC_W-1:0] pc,
                                               input int unsigned  idx_bits);
    return (pc >> 2) & ((PC_W'(1) << idx_bits) - PC_W'(1));
  endfunction

endpackage

// File: rtl/sat_counter2_next.sv
// Next state of a 2-bit saturating direction counter.
module sat_counter2_next
  import bp_pkg::*;
(
  input  logic [1:0] cur_i,
  input  logic       taken_i,
  output logic [1:0] next_o
);

  always_comb begin
    next_o = cur_i;
    if (taken_i) begin
      if (cur_i != ST) next_o = cur_i + 2'd1;
    end else begin
      if (cur_i != SNT) next_o = cur_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_outcome_predictor.sv
// Direct-mapped 2-bit counter branch predictor with mispredict redirect
// and saturating performance counters.
module branch_outcome_predictor
  import bp_pkg::*;
#(
  parameter int unsigned IDX_BITS   = 6,
  parameter logic [1:0]  INIT_STATE = WNT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] pred_pc,
  output logic            pred_taken,
  output logic            busy,
  input  logic            resolve_valid,
  input  logic [PC_W-1:0] resolve_pc,
  input  logic            resolve_taken,
  input  logic            resolve_pred,
  input  logic [PC_W-1:0] resolve_target,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] branch_count,
  output logic [PC_W-1:0] mispredict_count
);

  localparam int unsigned DEPTH = 2 ** IDX_BITS;

  bp_state_e           state_q, state_d;
  logic [IDX_BITS-1:0] sweep_idx_q, sweep_idx_d;
  logic                redirect_valid_q, redirect_valid_d;
  logic [PC_W-1:0]     redirect_pc_q, redirect_pc_d;
  logic [PC_W-1:0]     branch_cnt_q, branch_cnt_d;
  logic [PC_W-1:0]     mispred_cnt_q, mispred_cnt_d;

  logic [1:0]          table_q [DEPTH];

  logic [IDX_BITS-1:0] pred_idx, upd_idx, tbl_waddr;
  logic [1:0]          upd_next, tbl_wdata;
  logic                tbl_we, mispredict;

  assign pred_idx = IDX_BITS'(pc_index(pred_pc, IDX_BITS));
  assign upd_idx  = IDX_BITS'(pc_index(resolve_pc, IDX_BITS));

  sat_counter2_next u_sat_next (
    .cur_i   (table_q[upd_idx]),
    .taken_i (resolve_taken),
    .next_o  (upd_next)
  );

  // FSM next state and table write port: sweep in INIT, training in READY.
  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    tbl_we      = 1'b0;
    tbl_waddr   = upd_idx;
    tbl_wdata   = upd_next;
    case (state_q)
      S_INIT: begin
        tbl_we      = 1'b1;
        tbl_waddr   = sweep_idx_q;
        tbl_wdata   = INIT_STATE;
        sweep_idx_d = sweep_idx_q + IDX_BITS'(1);
        if (sweep_idx_q == IDX_BITS'(DEPTH - 1)) state_d = S_READY;
      end
      S_READY: begin
        tbl_we = resolve_valid;
      end
    endcase
  end

  // Redirect and performance counters run in both states.
  always_comb begin
    mispredict       = resolve_valid & (resolve_taken != resolve_pred);
    redirect_valid_d = mispredict;
    redirect_pc_d    = redirect_pc_q;
    branch_cnt_d     = branch_cnt_q;
    mispred_cnt_d    = mispred_cnt_q;
    if (mispredict) begin
      redirect_pc_d = resolve_taken ? resolve_target : resolve_pc + PC_STEP;
    end
    if (resolve_valid && (branch_cnt_q != '1)) begin
      branch_cnt_d = branch_cnt_q + PC_W'(1);
    end
    if (mispredict && (mispred_cnt_q != '1)) begin
      mispred_cnt_d = mispred_cnt_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= S_INIT;
      sweep_idx_q      <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      branch_cnt_q     <= '0;
      mispred_cnt_q    <= '0;
    end else begin
      state_q          <= state_d;
      sweep_idx_q      <= sweep_idx_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      branch_cnt_q     <= branch_cnt_d;
      mispred_cnt_q    <= mispred_cnt_d;
    end
  end

  // Table storage is left untouched by reset; the init sweep clears it.
  always_ff @(posedge clk) begin
    if (rst_n && tbl_we) table_q[tbl_waddr] <= tbl_wdata;
  end

  assign pred_taken       = (state_q == S_READY) & table_q[pred_idx][1];
  assign busy             = (state_q == S_INIT);
  assign redirect_valid   = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign branch_count     = branch_cnt_q;
  assign mispredict_count = mispred_cnt_q;

endmodule
